// File: rtl/rv32c_fetch_aligner_if.sv
// Handshake bundle between the fetch aligner, the instruction memory port and decode.
// The master modport is the aligner side; slave is the memory/consumer environment.
interface rv32c_fetch_aligner_if #(
    parameter int FETCH_WIDTH   = 32,
    parameter int BUF_HALFWORDS = 8
);
    localparam int CNT_W = $clog2(BUF_HALFWORDS) + 1;

    logic                   imem_req;
    logic [31:0]            imem_addr;
    logic                   imem_gnt;
    logic                   imem_rvalid;
    logic [FETCH_WIDTH-1:0] imem_rdata;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_inst;
    logic                   out_is_c;
    logic [31:0]            out_pc;
    logic [CNT_W-1:0]       buf_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output out_valid,
        input  out_ready,
        output out_inst, out_is_c, out_pc, buf_count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_inst, out_is_c, out_pc, buf_count
    );
endinterface

// File: rtl/rv32c_fetch_aligner.sv
// Fetches aligned imem words into a circular halfword buffer and hands out one raw
// 16- or 32-bit instruction per handshake with its PC, including straddling ones.
module rv32c_fetch_aligner #(
    parameter int          FETCH_WIDTH   = 32,
    parameter int          BUF_HALFWORDS = 8,
    parameter logic [31:0] RESET_PC      = 32'h0000_0200
) (
    input  logic                  CLK,
    input  logic                  RST,
    rv32c_fetch_aligner_if.master m
);
    localparam int FETCH_HW = FETCH_WIDTH / 16;
    localparam int OFF_W    = $clog2(FETCH_WIDTH / 8);
    localparam int DROP_W   = OFF_W - 1;
    localparam int PTR_W    = $clog2(BUF_HALFWORDS);
    localparam int CNT_W    = PTR_W + 1;

    logic [15:0]       hw_buf [BUF_HALFWORDS];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       fetch_pc;
    logic [31:0]       head_pc;
    logic              outstanding;
    logic              discard;
    logic [DROP_W-1:0] drop_cnt;

    logic [15:0]       hw0;
    logic [15:0]       hw1;
    logic              compressed;
    logic              pop;
    logic              accept;
    logic [CNT_W-1:0]  pop_n;
    logic [CNT_W-1:0]  push_n;

    assign hw0        = hw_buf[rd_ptr];
    assign hw1        = hw_buf[rd_ptr + PTR_W'(1)];
    assign compressed = hw0[1:0] != 2'b11;

    // A 32-bit instruction whose upper half has not arrived yet stays invisible.
    assign m.out_valid = (count >= CNT_W'(1) && compressed) || count >= CNT_W'(2);
    assign m.out_inst  = compressed ? {16'h0000, hw0} : {hw1, hw0};
    assign m.out_is_c  = compressed;
    assign m.out_pc    = head_pc;
    assign m.buf_count = count;

    // Only request when a whole word is guaranteed to fit, so the buffer cannot overflow.
    assign m.imem_addr = fetch_pc;
    assign m.imem_req  = !RST && !m.redirect && !outstanding &&
                         (count <= CNT_W'(BUF_HALFWORDS - FETCH_HW));

    assign pop    = m.out_valid && m.out_ready && !m.redirect;
    assign pop_n  = compressed ? CNT_W'(1) : CNT_W'(2);
    assign accept = !RST && !m.redirect && m.imem_rvalid && outstanding && !discard;
    assign push_n = CNT_W'(FETCH_HW) - CNT_W'(drop_cnt);

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_pc    <= {RESET_PC[31:OFF_W], {OFF_W{1'b0}}};
            head_pc     <= RESET_PC;
            drop_cnt    <= RESET_PC[OFF_W-1:1];
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (m.redirect) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_pc    <= {m.redirect_pc[31:OFF_W], {OFF_W{1'b0}}};
            head_pc     <= {m.redirect_pc[31:1], 1'b0};
            drop_cnt    <= m.redirect_pc[OFF_W-1:1];
            // A response still in flight belongs to the old stream and must be thrown away.
            discard     <= outstanding && !m.imem_rvalid;
            outstanding <= outstanding && !m.imem_rvalid;
        end else begin
            if (m.imem_req && m.imem_gnt) begin
                outstanding <= 1'b1;
                fetch_pc    <= fetch_pc + 32'(FETCH_WIDTH / 8);
            end
            if (m.imem_rvalid && outstanding) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
                if (!discard) begin
                    wr_ptr   <= wr_ptr + PTR_W'(push_n);
                    drop_cnt <= '0;
                end
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(pop_n);
                head_pc <= head_pc + (compressed ? 32'd2 : 32'd4);
            end
            count <= count + (accept ? push_n : '0) - (pop ? pop_n : '0);
        end
    end

    // Leading halfwords below the target PC are skipped when packing a word in.
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int j = 0; j < FETCH_HW; j++) begin
                if (j >= int'(drop_cnt))
                    hw_buf[wr_ptr + PTR_W'(j) - PTR_W'(drop_cnt)] <= m.imem_rdata[16*j +: 16];
            end
        end
    end

    rvalid_needs_request: assert property (@(posedge CLK) disable iff (RST)
        m.imem_rvalid |-> outstanding);
endmodule
